// File: rtl/edge_axil_pkg.sv
// ============================================================================
// Module  : edge_axil_pkg
// Brief   : Shared constants, FSM state types and sizing helpers for the
//           edge-detection AXI4-Lite register bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_axil_pkg;

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic int idx_width(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

  // Register stride in bytes is the bus width, so the index starts above these bits.
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_axil_wr_fsm.sv
// ============================================================================
// Module  : edge_axil_wr_fsm
// Brief   : Collects AW and W beats in either order and emits a single-cycle
//           commit with the merged address/data/strobe, then holds BVALID.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_axil_wr_fsm
  import edge_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic                    i_cm_err,
  output logic                    o_commit,
  output logic [ADDR_WIDTH-1:0]   o_cm_addr,
  output logic [DATA_WIDTH-1:0]   o_cm_data,
  output logic [DATA_WIDTH/8-1:0] o_cm_strb
);

  wr_state_t                r_state;
  wr_state_t                w_nxt;
  logic                     r_alive;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [DATA_WIDTH/8-1:0]  r_strb;
  logic [1:0]               r_bresp;

  // r_alive keeps the readys low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= W_IDLE;
      r_alive <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_bresp <= c_RESP_OKAY;
    end else begin
      r_state <= w_nxt;
      r_alive <= 1'b1;
      if (o_awready && i_awvalid) r_addr <= i_awaddr;
      if (o_wready && i_wvalid) begin
        r_data <= i_wdata;
        r_strb <= i_wstrb;
      end
      if (o_commit) r_bresp <= i_cm_err ? c_RESP_SLVERR : c_RESP_OKAY;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    o_awready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    o_commit  = 1'b0;
    o_cm_addr = r_addr;
    o_cm_data = r_data;
    o_cm_strb = r_strb;
    case (r_state)
      W_IDLE: begin
        o_awready = r_alive;
        o_wready  = r_alive;
        if (r_alive) begin
          if (i_awvalid && i_wvalid) begin
            o_commit  = 1'b1;
            o_cm_addr = i_awaddr;
            o_cm_data = i_wdata;
            o_cm_strb = i_wstrb;
            w_nxt     = W_RESP;
          end else if (i_awvalid) begin
            w_nxt = W_HAVE_ADDR;
          end else if (i_wvalid) begin
            w_nxt = W_HAVE_DATA;
          end
        end
      end
      W_HAVE_ADDR: begin
        o_wready = 1'b1;
        if (i_wvalid) begin
          o_commit  = 1'b1;
          o_cm_data = i_wdata;
          o_cm_strb = i_wstrb;
          w_nxt     = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        o_awready = 1'b1;
        if (i_awvalid) begin
          o_commit  = 1'b1;
          o_cm_addr = i_awaddr;
          w_nxt     = W_RESP;
        end
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_nxt = W_IDLE;
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  assign o_bresp = r_bresp;

endmodule

`default_nettype wire

// File: rtl/edge_axil_regbank.sv
// ============================================================================
// Module  : edge_axil_regbank
// Brief   : Parametrised AXI4-Lite register bank with byte strobes, hardware
//           fed read-only slots, per-register write pulses and SLVERR decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_axil_regbank
  import edge_axil_pkg::*;
#(
  parameter int                 NUM_REGS   = 8,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int c_SHIFT  = byte_shift(DATA_WIDTH);
  localparam int c_STRB_W = DATA_WIDTH / 8;

  logic                    w_commit;
  logic                    w_cm_err;
  logic [ADDR_WIDTH-1:0]   w_cm_addr;
  logic [DATA_WIDTH-1:0]   w_cm_data;
  logic [c_STRB_W-1:0]     w_cm_strb;
  logic [ADDR_WIDTH-1:0]   w_cm_idx;
  logic [NUM_REGS-1:0]     w_cm_hit;

  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]     r_wr_pulse;

  rd_state_t               r_rd_state;
  rd_state_t               w_rd_nxt;
  logic                    r_rd_alive;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic [ADDR_WIDTH-1:0]   w_ar_idx;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [1:0]              w_rd_resp;

  logic                    w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  edge_axil_wr_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_fsm (
    .clk       (ACLK),
    .rst       (ARESET),
    .i_awaddr  (S_AXI_AWADDR),
    .i_awvalid (S_AXI_AWVALID),
    .o_awready (S_AXI_AWREADY),
    .i_wdata   (S_AXI_WDATA),
    .i_wstrb   (S_AXI_WSTRB),
    .i_wvalid  (S_AXI_WVALID),
    .o_wready  (S_AXI_WREADY),
    .o_bresp   (S_AXI_BRESP),
    .o_bvalid  (S_AXI_BVALID),
    .i_bready  (S_AXI_BREADY),
    .i_cm_err  (w_cm_err),
    .o_commit  (w_commit),
    .o_cm_addr (w_cm_addr),
    .o_cm_data (w_cm_data),
    .o_cm_strb (w_cm_strb)
  );

  // A hit needs an in-range, writable slot; no hit means SLVERR.
  assign w_cm_idx = w_cm_addr >> c_SHIFT;

  always_comb begin
    w_cm_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cm_hit[i] = (w_cm_idx == ADDR_WIDTH'(i)) && !RO_MASK[i];
    end
  end

  assign w_cm_err = ~|w_cm_hit;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_cm_hit[i]) begin
            r_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < c_STRB_W; b++) begin
              if (w_cm_strb[b]) r_regs[i][b*8 +: 8] <= w_cm_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  assign wr_pulse = r_wr_pulse;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      if (RO_MASK[gi]) begin : g_ro
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_rw
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
      end
    end
  endgenerate

  assign w_ar_idx = S_AXI_ARADDR >> c_SHIFT;

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = c_RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == ADDR_WIDTH'(i)) begin
        w_rd_resp = c_RESP_OKAY;
        w_rd_data = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  // Read data is sampled on the AR edge, so a same-edge write is not yet visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rd_state <= R_IDLE;
      r_rd_alive <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= c_RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_nxt;
      r_rd_alive <= 1'b1;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

  always_comb begin
    w_rd_nxt      = r_rd_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        S_AXI_ARREADY = r_rd_alive;
        if (r_rd_alive && S_AXI_ARVALID) w_rd_nxt = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) w_rd_nxt = R_IDLE;
      end
      default: w_rd_nxt = R_IDLE;
    endcase
  end

  assign S_AXI_RDATA = r_rdata;
  assign S_AXI_RRESP = r_rresp;

endmodule

`default_nettype wire

// File: tb/tb_edge_axil_regbank.sv
// ============================================================================
// Module  : tb_edge_axil_regbank
// Brief   : Self-checking bench for edge_axil_regbank against a register-array
//           reference model with directed and random AXI4-Lite traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_edge_axil_regbank;

  localparam int            NR = 8;
  localparam int            DW = 32;
  localparam int            AW = 8;
  localparam logic [NR-1:0] RO = 8'b0000_0100;

  logic             ACLK = 1'b0;
  logic             ARESET = 1'b1;
  logic [AW-1:0]    S_AXI_AWADDR = '0;
  logic [2:0]       S_AXI_AWPROT = '0;
  logic             S_AXI_AWVALID = 1'b0;
  logic             S_AXI_AWREADY;
  logic [DW-1:0]    S_AXI_WDATA = '0;
  logic [DW/8-1:0]  S_AXI_WSTRB = '0;
  logic             S_AXI_WVALID = 1'b0;
  logic             S_AXI_WREADY;
  logic [1:0]       S_AXI_BRESP;
  logic             S_AXI_BVALID;
  logic             S_AXI_BREADY = 1'b0;
  logic [AW-1:0]    S_AXI_ARADDR = '0;
  logic [2:0]       S_AXI_ARPROT = '0;
  logic             S_AXI_ARVALID = 1'b0;
  logic             S_AXI_ARREADY;
  logic [DW-1:0]    S_AXI_RDATA;
  logic [1:0]       S_AXI_RRESP;
  logic             S_AXI_RVALID;
  logic             S_AXI_RREADY = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] hw_in = '0;
  logic [NR-1:0]    wr_pulse;

  int               n_chk = 0;
  int               n_err = 0;
  logic [DW-1:0]    m_regs [NR];

  edge_axil_regbank #(
    .NUM_REGS   (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RO_MASK    (RO)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_out       (reg_out),
    .hw_in         (hw_in),
    .wr_pulse      (wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_ro(input int i);
    return RO[i];
  endfunction

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) if (!is_ro(i)) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return S_AXI_AWREADY;
      1:       return S_AXI_WREADY;
      2:       return S_AXI_ARREADY;
      3:       return S_AXI_BVALID;
      4:       return S_AXI_RVALID;
      default: return 1'b0;
    endcase
  endfunction

  // Returns at a negedge where the selected signal is high, or after a bounded wait.
  task automatic wait_on(input string tag, input int which);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!sig(which) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!sig(which)) chk({tag, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input int mode, input int bdly, output logic [1:0] resp);
    int            idx;
    bit            ok;
    logic [NR-1:0] ep;
    logic [1:0]    er;
    idx = int'(a) / 4;
    ok  = (idx < NR) && !is_ro(idx);
    ep  = ok ? (NR'(1) << idx) : '0;
    er  = ok ? 2'b00 : 2'b10;
    S_AXI_AWADDR = a;
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    if (mode == 0) begin
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      wait_on("aw_w", 0);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
    end else if (mode == 1) begin
      S_AXI_WVALID = 1'b1;
      wait_on("w_first", 1);
      @(posedge ACLK); #1;
      S_AXI_WVALID  = 1'b0;
      S_AXI_AWVALID = 1'b1;
      wait_on("aw_second", 0);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
    end else begin
      S_AXI_AWVALID = 1'b1;
      wait_on("aw_first", 0);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b1;
      wait_on("w_second", 1);
      @(posedge ACLK); #1;
      S_AXI_WVALID = 1'b0;
    end
    chk("wr_pulse", 256'(wr_pulse), 256'(ep));
    chk("bvalid_with_pulse", 256'(S_AXI_BVALID), 256'(1));
    if (ok) for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
    @(posedge ACLK); #1;
    chk("wr_pulse_drop", 256'(wr_pulse), 256'(0));
    chk("reg_out", 256'(reg_out), 256'(m_flat()));
    repeat (bdly) @(posedge ACLK);
    #1;
    S_AXI_BREADY = 1'b1;
    wait_on("bvalid", 3);
    resp = S_AXI_BRESP;
    chk("bresp", 256'(S_AXI_BRESP), 256'(er));
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int rdly,
                          output logic [DW-1:0] data, output logic [1:0] resp);
    int            idx;
    logic [DW-1:0] ed;
    logic [1:0]    er;
    idx = int'(a) / 4;
    if (idx >= NR) begin
      ed = '0;
      er = 2'b10;
    end else if (is_ro(idx)) begin
      ed = hw_in[idx*DW +: DW];
      er = 2'b00;
    end else begin
      ed = m_regs[idx];
      er = 2'b00;
    end
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    wait_on("arready", 2);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_latency", 256'(S_AXI_RVALID), 256'(1));
    repeat (rdly) @(posedge ACLK);
    #1;
    S_AXI_RREADY = 1'b1;
    wait_on("rvalid", 4);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    chk("rdata", 256'(S_AXI_RDATA), 256'(ed));
    chk("rresp", 256'(S_AXI_RRESP), 256'(er));
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [DW-1:0] d;

    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      hw_in[i*DW +: DW] = $urandom;
    end
    hw_in[2*DW +: DW] = 32'hA5A5A5A5;

    // Reset state
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_readys", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'(0));
    chk("rst_valids", 256'({S_AXI_BVALID, S_AXI_RVALID}), 256'(0));
    chk("rst_resps", 256'({S_AXI_BRESP, S_AXI_RRESP}), 256'(0));
    chk("rst_rdata", 256'(S_AXI_RDATA), 256'(0));
    chk("rst_reg_out", 256'(reg_out), 256'(0));
    chk("rst_wr_pulse", 256'(wr_pulse), 256'(0));
    ARESET = 1'b0;
    #1;
    chk("readys_before_edge", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'(0));
    @(posedge ACLK); #1;
    chk("readys_after_edge", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'(3'b111));

    // Basic write/readback
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, r);
    chk("deadbeef_bresp", 256'(r), 256'(2'b00));
    axi_read(8'h04, 0, d, r);
    chk("deadbeef_read", 256'(d), 256'(32'hDEADBEEF));

    // Byte strobes, both AW/W orderings
    axi_write(8'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, r);
    axi_write(8'h0C, 32'h11223344, 4'b0101, 1, 1, r);
    axi_read(8'h0C, 0, d, r);
    chk("strb_w_first", 256'(d), 256'(32'hFF22FF44));
    axi_write(8'h10, 32'hFFFFFFFF, 4'hF, 0, 0, r);
    axi_write(8'h10, 32'h11223344, 4'b0101, 2, 0, r);
    axi_read(8'h10, 1, d, r);
    chk("strb_aw_first", 256'(d), 256'(32'hFF22FF44));
    axi_write(8'h14, 32'h01020304, 4'b0000, 0, 0, r);
    chk("zero_strb_okay", 256'(r), 256'(2'b00));

    // Read-only slot
    axi_read(8'h08, 0, d, r);
    chk("ro_read", 256'(d), 256'(32'hA5A5A5A5));
    axi_write(8'h08, 32'h12345678, 4'hF, 0, 0, r);
    chk("ro_write_slverr", 256'(r), 256'(2'b10));
    axi_read(8'h08, 0, d, r);
    chk("ro_unchanged", 256'(d), 256'(32'hA5A5A5A5));

    // Out-of-range index
    axi_write(8'h20, 32'hCAFEBABE, 4'hF, 2, 0, r);
    chk("oor_write_slverr", 256'(r), 256'(2'b10));
    axi_read(8'h23, 0, d, r);
    chk("oor_read_data", 256'(d), 256'(0));
    chk("oor_read_resp", 256'(r), 256'(2'b10));

    // Simultaneous read/write of reg 0, then back-pressure on both responses
    axi_write(8'h00, 32'h12345678, 4'hF, 0, 0, r);
    S_AXI_AWADDR  = 8'h00;
    S_AXI_WDATA   = 32'hCAFEF00D;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_ARADDR  = 8'h00;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    chk("all_ready_idle", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'(3'b111));
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    S_AXI_AWADDR = 8'h04;
    S_AXI_ARADDR = 8'h04;
    chk("sim_wr_pulse", 256'(wr_pulse), 256'(8'b0000_0001));
    m_regs[0] = 32'hCAFEF00D;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      chk("stall_hold", 256'({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RDATA,
                              S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}),
          256'({1'b1, 1'b1, 2'b00, 32'h12345678, 3'b000}));
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_RREADY  = 1'b1;
    @(negedge ACLK);
    chk("stall_release", 256'({S_AXI_BVALID, S_AXI_RVALID}), 256'(2'b11));
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    axi_read(8'h00, 0, d, r);
    chk("sim_new_value", 256'(d), 256'(32'hCAFEF00D));

    // Randomized traffic against the model
    for (int t = 0; t < 80; t++) begin
      int            idx;
      logic [AW-1:0] a;
      if (t % 16 == 0) for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = $urandom;
      idx = int'($urandom_range(0, 9));
      a   = AW'(idx * 4 + int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r);
      else
        axi_read(a, int'($urandom_range(0, 2)), d, r);
    end

    // Reset while the write FSM holds an address
    S_AXI_AWADDR  = 8'h04;
    S_AXI_AWVALID = 1'b1;
    wait_on("aw_abort", 0);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("abort_ctrl", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                            S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, wr_pulse}), 256'(0));
    chk("abort_rdata", 256'(S_AXI_RDATA), 256'(0));
    chk("abort_reg_out", 256'(reg_out), 256'(0));
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    axi_write(8'h04, 32'h55AA55AA, 4'hF, 0, 0, r);
    chk("post_abort_bresp", 256'(r), 256'(2'b00));
    axi_read(8'h04, 0, d, r);
    chk("post_abort_read", 256'(d), 256'(32'h55AA55AA));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edge_axil_regbank.md
# edge_axil_regbank

Parametrised AXI4-Lite slave register bank for the edge-detection IP family. It replaces the fixed four-register slave with configurable register count and data width, byte-strobe writes, hardware-fed read-only registers, per-register write strobes and error responses for illegal accesses. It sits between the PS interconnect and the edge-detection datapath, exporting control registers and importing status.

## Interface
- NUM_REGS, 8, number of 32-bit-aligned registers (2..64)
- DATA_WIDTH, 32, AXI data width (32 or 64); address stride stays 4 bytes for 32, 8 for 64
- ADDR_WIDTH, 8, AXI address width; must cover NUM_REGS × (DATA_WIDTH/8)
- RO_MASK, 0, NUM_REGS-bit mask; bit i set = register i is read-only, sourced from hw_in
- ACLK  in  1  clock
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID  in  ADDR_WIDTH / 3 / 1  write address channel; AWPROT ignored
- S_AXI_AWREADY  out  1
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write data channel
- S_AXI_WREADY  out  1
- S_AXI_BRESP / S_AXI_BVALID  out  2 / 1;  S_AXI_BREADY  in  1
- S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID  in  ADDR_WIDTH / 3 / 1;  S_AXI_ARREADY  out  1
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID  out  DATA_WIDTH / 2 / 1;  S_AXI_RREADY  in  1
- reg_out  out  NUM_REGS×DATA_WIDTH  current RW register contents (RO slots drive 0)
- hw_in  in  NUM_REGS×DATA_WIDTH  status values for RO registers (RW slots ignored)
- wr_pulse  out  NUM_REGS  one-cycle strobe on the commit cycle of a successful write to register i

## Operation
- Decode: index = ADDR >> log2(DATA_WIDTH/8); low address bits ignored. index ≥ NUM_REGS → SLVERR (2'b10).
- Write FSM: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AWREADY=WREADY=1. AW and W same cycle → commit, go W_RESP. AW only → W_HAVE_ADDR (address latched). W only → W_HAVE_DATA (data+strobe latched).
  - W_HAVE_ADDR: WREADY=1, AWREADY=0; on W handshake commit → W_RESP. W_HAVE_DATA symmetric.
  - W_RESP: BVALID=1, no readys; BVALID&BREADY → W_IDLE.
- Commit: RW in-range register updated byte-wise where WSTRB set; wr_pulse[index] asserted. WSTRB=0 still OKAY and pulses. RO target or out-of-range: no update, no pulse, BRESP=SLVERR.
- Read FSM: R_IDLE (ARREADY=1), R_DATA (RVALID=1). AR handshake captures RDATA (RW: register, RO: hw_in slice, out-of-range: 0 with SLVERR) → R_DATA; RVALID&RREADY → R_IDLE.
- Read and write channels independent; both may be in flight.

## Timing
- Reset: all registers 0, all readys 0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse=0, FSMs idle. Readys rise on first ACLK edge after ARESET falls.
- Write commit on the edge completing the second of AW/W (same edge if simultaneous); reg_out and wr_pulse visible the following cycle, BVALID same cycle as wr_pulse.
- Read latency: RVALID one cycle after AR handshake; RDATA held stable until RREADY.
- Read and write to the same register on the same edge: read returns pre-write value.
- Maximum throughput: one write per 2 cycles with BREADY held high, one read per 2 cycles.
- BVALID/RVALID never drop without handshake; BREADY/RREADY low stalls indefinitely with no loss.
- ARESET mid-transaction: immediate abort, outstanding responses discarded, registers cleared.

## Structure
- Package edge_axil_pkg: resp constants (OKAY 2'b00, SLVERR 2'b10), write/read state enums, function for index width.
- Sub-module edge_axil_wr_fsm: AW/W collection and commit generation; read path and register array stay in top.

## Test plan
- Reset, then write 0xDEADBEEF to reg 1 (AW, W same cycle) → BRESP OKAY, wr_pulse[1] one cycle, readback 0xDEADBEEF.
- W one cycle before AW, then AW before W, WSTRB=4'b0101, data 0x11223344 over 0xFFFFFFFF → reg = 0xFF22FF44 both orderings.
- RO_MASK bit 2 set, hw_in[2]=0xA5A5A5A5: read reg 2 → 0xA5A5A5A5 OKAY; write reg 2 → SLVERR, no pulse, value unchanged.
- Address index NUM_REGS: write → SLVERR, read → RDATA 0, RRESP SLVERR.
- BREADY/RREADY held low 10 cycles → BVALID/RVALID/RDATA stable, no new AW/AR accepted; simultaneous read/write reg 0 returns old value.
- Assert ARESET during W_HAVE_ADDR → all outputs and registers 0 next cycle, fresh write succeeds after release.
